bram_arbiter: RTL and testbench

// - Shares the single-port, write-first block RAM (1-cycle registered read) between two requesters.
//   - Port 0 is the CPU memory interface.
//   - Port 1 is the program loader / debug port.
// - Sits between the requesters and the RAM; owns every RAM control pin.
// - Fully pipelined: accepts one access per cycle and returns read data/completion 2 cycles after grant.

---
 rtl/bram_arbiter_pkg.sv | 16 +
 rtl/bram_arbiter_rr_arb2.sv | 39 +++
 rtl/bram_arbiter.sv | 102 ++++++++++
 tb/tb_bram_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arbiter_pkg.sv
// Shared definitions for the two-port block-RAM arbiter: port ids and the
// pipeline tag that travels with each granted access.
package bram_arbiter_pkg;

  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef struct packed {
    logic valid;
    logic id;
    logic wr;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: 1'b0, wr: 1'b0};

endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// Two-way arbiter: fixed priority to port 0, or round-robin using a
// last-grant flop that resets to "port 1 last".
module bram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       rr_i,
  output logic [1:0] gnt_o
);

  // 1 = port 1 was granted most recently
  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (rr_i && !last_q) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares a single-port write-first BRAM between the CPU (port 0) and the
// loader/debug port (port 1); one access per cycle, done 2 cycles after grant.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter int DATA = 16,
  parameter int ADDR = 12,
  parameter int RR   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_req,
  input  logic            p0_wr,
  input  logic [ADDR-1:0] p0_addr,
  input  logic [DATA-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_done,
  output logic [DATA-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_wr,
  input  logic [ADDR-1:0] p1_addr,
  input  logic [DATA-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_done,
  output logic [DATA-1:0] p1_rdata,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  // Handshake: a request is consumed in the cycle its gnt is high; the
  // requester holds req/wr/addr/wdata stable until then. done has no stall.

  logic [1:0] req;
  logic [1:0] gnt;

  // Masking with rst_n keeps gnt low for the whole reset window.
  assign req = {p1_req, p0_req} & {2{rst_n}};

  bram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .rr_i  (RR != 0),
    .gnt_o (gnt)
  );

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];

  logic            mem_wr_q,   mem_wr_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [DATA-1:0] mem_din_q,  mem_din_d;
  tag_t            tag1_q,     tag1_d;
  tag_t            tag2_q;

  always_comb begin
    mem_wr_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    tag1_d     = TAG_IDLE;
    if (gnt[1]) begin
      mem_wr_d   = p1_wr;
      mem_addr_d = p1_addr;
      mem_din_d  = p1_wdata;
      tag1_d     = '{valid: 1'b1, id: 1'(PORT_DBG), wr: p1_wr};
    end else if (gnt[0]) begin
      mem_wr_d   = p0_wr;
      mem_addr_d = p0_addr;
      mem_din_d  = p0_wdata;
      tag1_d     = '{valid: 1'b1, id: 1'(PORT_CPU), wr: p0_wr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      tag1_q     <= TAG_IDLE;
      tag2_q     <= TAG_IDLE;
    end else begin
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      tag1_q     <= tag1_d;
      tag2_q     <= tag1_q;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;

  // Write completions return 0: the RAM's write-first dout is not forwarded.
  assign p0_done  = tag2_q.valid && (tag2_q.id == 1'(PORT_CPU));
  assign p1_done  = tag2_q.valid && (tag2_q.id == 1'(PORT_DBG));
  assign p0_rdata = (p0_done && !tag2_q.wr) ? mem_dout : '0;
  assign p1_rdata = (p1_done && !tag2_q.wr) ? mem_dout : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: one round-robin instance and one
// fixed-priority instance, each with a behavioural write-first RAM.
module tb_bram_arbiter;

  logic clk;
  logic rst_n;

  // round-robin instance
  logic        p0_req, p0_wr, p0_gnt, p0_done;
  logic [11:0] p0_addr;
  logic [15:0] p0_wdata, p0_rdata;
  logic        p1_req, p1_wr, p1_gnt, p1_done;
  logic [11:0] p1_addr;
  logic [15:0] p1_wdata, p1_rdata;
  logic        mem_wr;
  logic [11:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic [15:0] ram [0:4095];

  // fixed-priority instance
  logic        f_p0_req, f_p0_gnt, f_p0_done;
  logic [15:0] f_p0_rdata;
  logic        f_p1_req, f_p1_gnt, f_p1_done;
  logic [15:0] f_p1_rdata;
  logic        f_mem_wr;
  logic [11:0] f_mem_addr;
  logic [15:0] f_mem_din, f_mem_dout;
  logic [15:0] f_ram [0:4095];

  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q [$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_arbiter #(.DATA(16), .ADDR(12), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  bram_arbiter #(.DATA(16), .ADDR(12), .RR(0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(f_p0_req), .p0_wr(1'b0), .p0_addr(12'h000), .p0_wdata(16'h0000),
    .p0_gnt(f_p0_gnt), .p0_done(f_p0_done), .p0_rdata(f_p0_rdata),
    .p1_req(f_p1_req), .p1_wr(1'b0), .p1_addr(12'h001), .p1_wdata(16'h0000),
    .p1_gnt(f_p1_gnt), .p1_done(f_p1_done), .p1_rdata(f_p1_rdata),
    .mem_wr(f_mem_wr), .mem_addr(f_mem_addr), .mem_din(f_mem_din), .mem_dout(f_mem_dout)
  );

  // write-first RAMs with a registered read
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_din;
      mem_dout      <= mem_din;
    end else begin
      mem_dout <= ram[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (f_mem_wr) begin
      f_ram[f_mem_addr] <= f_mem_din;
      f_mem_dout        <= f_mem_din;
    end else begin
      f_mem_dout <= f_ram[f_mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic p0_set(input logic req, input logic wr, input logic [11:0] a, input logic [15:0] d);
    p0_req = req; p0_wr = wr; p0_addr = a; p0_wdata = d;
  endtask

  task automatic p1_set(input logic req, input logic wr, input logic [11:0] a, input logic [15:0] d);
    p1_req = req; p1_wr = wr; p1_addr = a; p1_wdata = d;
  endtask

  initial begin
    logic [16:0] e;
    int ndone;
    logic [11:0] xa [4] = '{12'h000, 12'hFFF, 12'h000, 12'hFFF};
    logic        xw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] xd [4] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000};

    rst_n = 1'b0;
    p0_set(1'b0, 1'b0, 12'h000, 16'h0000);
    p1_set(1'b0, 1'b0, 12'h000, 16'h0000);
    f_p0_req = 1'b0;
    f_p1_req = 1'b0;
    sample();
    sample();
    check("rst_p0_gnt", 32'(p0_gnt), 0);
    check("rst_p0_done", 32'(p0_done), 0);
    check("rst_p1_done", 32'(p1_done), 0);
    check("rst_p0_rdata", 32'(p0_rdata), 0);
    check("rst_mem_wr", 32'(mem_wr), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", 32'(mem_din), 0);
    rst_n = 1'b1;

    // preload through the loader port
    tick(); p1_set(1'b1, 1'b1, 12'h010, 16'hBEEF);
    sample(); check("pre_gnt1", 32'(p1_gnt), 1);
    tick(); p1_set(1'b1, 1'b1, 12'h020, 16'hA0A0);
    tick(); p1_set(1'b1, 1'b1, 12'h030, 16'hB1B1);
    sample(); check("pre_wr_done", 32'(p1_done), 1);
    check("pre_wr_rdata0", 32'(p1_rdata), 0);
    tick(); p1_set(1'b0, 1'b0, 12'h000, 16'h0000);
    tick(); tick(); tick();

    // single read
    p0_set(1'b1, 1'b0, 12'h010, 16'h0000);
    sample();
    check("t1_gnt0", 32'(p0_gnt), 1);
    check("t1_gnt1", 32'(p1_gnt), 0);
    tick(); p0_set(1'b0, 1'b0, 12'h000, 16'h0000);
    sample();
    check("t1_n1_done", 32'(p0_done), 0);
    check("t1_n1_addr", 32'(mem_addr), 32'h010);
    check("t1_n1_wr", 32'(mem_wr), 0);
    tick(); sample();
    check("t1_done", 32'(p0_done), 1);
    check("t1_rdata", 32'(p0_rdata), 32'hBEEF);
    check("t1_p1_silent", 32'(p1_done), 0);
    tick(); sample();
    check("t1_done_end", 32'(p0_done), 0);
    check("t1_rdata_end", 32'(p0_rdata), 0);

    // write then read, loader port
    tick(); p1_set(1'b1, 1'b1, 12'h0FF, 16'h1234);
    sample(); check("t2_gnt_w", 32'(p1_gnt), 1);
    tick(); p1_set(1'b1, 1'b0, 12'h0FF, 16'h0000);
    sample();
    check("t2_gnt_r", 32'(p1_gnt), 1);
    check("t2_mem_wr", 32'(mem_wr), 1);
    check("t2_mem_addr", 32'(mem_addr), 32'h0FF);
    check("t2_mem_din", 32'(mem_din), 32'h1234);
    tick(); p1_set(1'b0, 1'b0, 12'h000, 16'h0000);
    sample();
    check("t2_done_w", 32'(p1_done), 1);
    check("t2_rdata_w", 32'(p1_rdata), 0);
    tick(); sample();
    check("t2_done_r", 32'(p1_done), 1);
    check("t2_rdata_r", 32'(p1_rdata), 32'h1234);
    tick(); sample();
    check("t2_done_end", 32'(p1_done), 0);

    // round-robin contention; port 1 was granted last
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 6) begin
        p0_set(1'b1, 1'b0, 12'h020, 16'h0000);
        p1_set(1'b1, 1'b0, 12'h030, 16'h0000);
      end else begin
        p0_set(1'b0, 1'b0, 12'h000, 16'h0000);
        p1_set(1'b0, 1'b0, 12'h000, 16'h0000);
      end
      sample();
      if (i < 6) begin
        check("rr_gnt0", 32'(p0_gnt), 32'((i % 2) == 0));
        check("rr_gnt1", 32'(p1_gnt), 32'((i % 2) == 1));
      end
      if (p0_done || p1_done) begin
        ndone++;
        if (exp_q.size() == 0) begin
          check("rr_sb_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rr_done_id", 32'(p1_done), 32'(e[16]));
          check("rr_done_data", 32'(p1_done ? p1_rdata : p0_rdata), 32'(e[15:0]));
        end
      end
      if (p0_gnt) exp_q.push_back({1'b0, 16'hA0A0});
      if (p1_gnt) exp_q.push_back({1'b1, 16'hB1B1});
    end
    check("rr_done_count", 32'(ndone), 6);

    // reset mid-flight
    tick(); p0_set(1'b1, 1'b0, 12'h010, 16'h0000);
    sample(); check("rs_gnt0", 32'(p0_gnt), 1);
    tick();
    p0_set(1'b1, 1'b0, 12'h020, 16'h0000);
    p1_set(1'b1, 1'b0, 12'h030, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    check("rs_gnt0_low", 32'(p0_gnt), 0);
    check("rs_gnt1_low", 32'(p1_gnt), 0);
    check("rs_mem_addr", 32'(mem_addr), 0);
    check("rs_mem_wr", 32'(mem_wr), 0);
    check("rs_done0", 32'(p0_done), 0);
    @(posedge clk);
    sample();
    check("rs_no_done", 32'(p0_done), 0);
    check("rs_rdata", 32'(p0_rdata), 0);
    rst_n = 1'b1;
    #1;
    check("rs_tie_gnt0", 32'(p0_gnt), 1);
    check("rs_tie_gnt1", 32'(p1_gnt), 0);
    tick();
    p0_set(1'b0, 1'b0, 12'h000, 16'h0000);
    p1_set(1'b0, 1'b0, 12'h000, 16'h0000);
    tick(); sample();
    check("rs_post_done", 32'(p0_done), 1);
    check("rs_post_rdata", 32'(p0_rdata), 32'hA0A0);

    // address extremes
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) p0_set(1'b1, xw[i], xa[i], xd[i]);
      else       p0_set(1'b0, 1'b0, 12'h000, 16'h0000);
      sample();
      if (i < 4) check("ax_gnt", 32'(p0_gnt), 1);
      if (i == 2) begin
        check("ax_mem_addr", 32'(mem_addr), 32'hFFF);
        check("ax_mem_din", 32'(mem_din), 32'h2222);
        check("ax_wr_rdata", 32'(p0_rdata), 0);
      end
      if (i == 4) check("ax_rd_000", 32'(p0_rdata), 32'h1111);
      if (i == 5) check("ax_rd_fff", 32'(p0_rdata), 32'h2222);
    end

    // fixed priority: port 0 always wins
    for (int i = 0; i < 6; i++) begin
      tick();
      f_p0_req = (i < 4);
      f_p1_req = (i < 5);
      sample();
      if (i < 4) begin
        check("fp_gnt0", 32'(f_p0_gnt), 1);
        check("fp_gnt1", 32'(f_p1_gnt), 0);
      end
      if (i == 4) begin
        check("fp_p1_gnt", 32'(f_p1_gnt), 1);
        check("fp_p0_nogt", 32'(f_p0_gnt), 0);
      end
      if (i == 5) check("fp_p0_done", 32'(f_p0_done), 1);
    end
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
